lock_access_arbiter: RTL and testbench

- Arbitrates two requesters (credential channels 0 and 1) for one shared lock actuator.
- Sequences the actuator through arm, hold and release phases, with an ack handshake and a timeout watchdog.
- Sits between the credential-checking FSMs and the actuator pins in the tt_um top.
- Round-robin fairness; a fault latches until software/pin clear.

---
 rtl/lock_access_arbiter_if.sv | 24 ++
 rtl/lock_access_arbiter.sv | 153 +++++++++++++++
 tb/tb_lock_access_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lock_access_arbiter_if.sv
// Requester/actuator signal bundle for lock_access_arbiter; master drives requests and ack,
// slave (the arbiter) drives grants, actuator controls and status.
interface lock_access_arbiter_if;
    logic [1:0] req;
    logic       act_ack;
    logic       clr_err;
    logic [1:0] gnt;
    logic       act_en;
    logic       act_sel;
    logic       busy;
    logic [1:0] done;
    logic       err;
    logic [2:0] state_o;

    modport master (
        output req, act_ack, clr_err,
        input  gnt, act_en, act_sel, busy, done, err, state_o
    );

    modport slave (
        input  req, act_ack, clr_err,
        output gnt, act_en, act_sel, busy, done, err, state_o
    );
endinterface

// File: rtl/lock_access_arbiter.sv
// Round-robin arbiter sequencing a shared lock actuator through ARM/HOLD/REL with ack timeouts; grant one edge after request.
// No backpressure: requests are level and held until done/err; ena=0 freezes everything, faults latch until clr_err.
module lock_access_arbiter #(
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    lock_access_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_ARM  = 3'b001,
        S_HOLD = 3'b010,
        S_REL  = 3'b011,
        S_ERR  = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             act_en_q, act_en_d;
    logic             busy_q, busy_d;
    logic [1:0]       done_q, done_d;
    logic             err_q, err_d;
    logic             own;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        act_en_d = act_en_q;
        busy_d   = busy_q;
        err_d    = err_q;
        done_d   = 2'b00;
        own      = 1'b0;

        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    // On a tie the channel that did not finish last wins.
                    own = bus.req[0] ? (bus.req[1] ? ~last_q : 1'b0) : 1'b1;
                    if (|bus.req) begin
                        state_d  = S_ARM;
                        sel_d    = own;
                        gnt_d    = own ? 2'b10 : 2'b01;
                        act_en_d = 1'b1;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                    end
                end
                S_ARM: begin
                    if (bus.act_ack) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d  = S_ERR;
                        gnt_d    = 2'b00;
                        act_en_d = 1'b0;
                        err_d    = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (!bus.req[sel_q] || cnt_q == HOLD_LAST) begin
                        state_d  = S_REL;
                        act_en_d = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_REL: begin
                    if (!bus.act_ack) begin
                        state_d = S_IDLE;
                        gnt_d   = 2'b00;
                        busy_d  = 1'b0;
                        done_d  = sel_q ? 2'b10 : 2'b01;
                        last_d  = sel_q;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = S_ERR;
                        gnt_d   = 2'b00;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_ERR: begin
                    if (bus.clr_err) begin
                        state_d = S_IDLE;
                        err_d   = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    gnt_d    = 2'b00;
                    act_en_d = 1'b0;
                    busy_d   = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            gnt_q    <= 2'b00;
            act_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            gnt_q    <= gnt_d;
            act_en_q <= act_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.act_en  = act_en_q;
    assign bus.act_sel = sel_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_lock_access_arbiter.sv
// Directed walk through the lock sequences followed by randomized traffic,
// every cycle compared against a phase/elapsed-cycle model of the arbiter.
module tb_lock_access_arbiter;

    localparam int HOLD = 4;
    localparam int TO   = 6;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    int   checks   = 0;
    int   failures = 0;

    lock_access_arbiter_if bus ();

    lock_access_arbiter #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 arm, 2 hold, 3 rel, 4 err; spent = cycles spent in current phase.
    int         m_ph   = 0;
    int         m_spent = 0;
    int         m_own  = 0;
    int         m_last = 1;
    logic [1:0] m_done = 2'b00;

    function automatic logic m_act_en();
        return (m_ph == 1) || (m_ph == 2);
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [1:0] g;
        g = (m_ph >= 1 && m_ph <= 3) ? ((m_own == 1) ? 2'b10 : 2'b01) : 2'b00;
        return {g, m_act_en(), 1'(m_own), (m_ph != 0), m_done, (m_ph == 4), 3'(m_ph)};
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_ph = 0; m_spent = 0; m_own = 0; m_last = 1; m_done = 2'b00;
        end else if (!ena) begin
            m_done = 2'b00;
        end else begin
            m_done = 2'b00;
            case (m_ph)
                0: if (bus.req != 2'b00) begin
                    if (bus.req == 2'b11) m_own = 1 - m_last;
                    else                  m_own = bus.req[1] ? 1 : 0;
                    m_ph = 1; m_spent = 1;
                end
                1: if (bus.act_ack) begin m_ph = 2; m_spent = 1; end
                   else if (m_spent == TO) m_ph = 4;
                   else m_spent++;
                2: if (!bus.req[m_own] || m_spent == HOLD) begin m_ph = 3; m_spent = 1; end
                   else m_spent++;
                3: if (!bus.act_ack) begin
                       m_ph = 0; m_last = m_own;
                       m_done = (m_own == 1) ? 2'b10 : 2'b01;
                   end else if (m_spent == TO) m_ph = 4;
                   else m_spent++;
                default: if (bus.clr_err) m_ph = 0;
            endcase
        end
    endtask

    task automatic tick(input string tag);
        logic [10:0] obs;
        logic [10:0] exp;
        @(posedge clk);
        model_step();
        #1;
        obs = {bus.gnt, bus.act_en, bus.act_sel, bus.busy, bus.done, bus.err, bus.state_o};
        exp = exp_vec();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (gnt,act_en,sel,busy,done,err,state)", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    logic [1:0] seen [3];
    int         nseen;

    initial begin
        rst_n = 1'b0; ena = 1'b1;
        bus.req = 2'b00; bus.act_ack = 1'b0; bus.clr_err = 1'b0;
        ticks("reset", 2);
        chk("reset_state", {1'b0, bus.state_o}, 4'h0);
        chk("reset_outs", {bus.gnt, bus.act_en, bus.busy}, 4'h0);
        chk("reset_done_err", {bus.done, bus.err, bus.act_sel}, 4'h0);
        rst_n = 1'b1;

        // Basic single-request sequence.
        bus.req = 2'b01;
        tick("t1_grant");
        chk("t1_gnt", {bus.gnt, bus.act_en, bus.busy}, 4'b0111);
        tick("t1_arm2");
        bus.act_ack = 1'b1;
        tick("t1_hold");
        chk("t1_hold_state", {1'b0, bus.state_o}, 4'd2);
        ticks("t1_hold", 3);
        chk("t1_still_hold", {1'b0, bus.state_o}, 4'd2);
        tick("t1_rel");
        chk("t1_rel", {bus.state_o, bus.act_en}, 4'b0110);
        bus.act_ack = 1'b0; bus.req = 2'b00;
        tick("t1_done");
        chk("t1_done", {bus.done, bus.busy, bus.act_en}, 4'b0100);
        tick("t1_done_clear");
        chk("t1_done_pulse", {2'b00, bus.done}, 4'h0);

        // Both channels requesting from reset: alternating grants.
        rst_n = 1'b0; tick("t2_reset"); rst_n = 1'b1;
        bus.req = 2'b11;
        nseen = 0;
        for (int i = 0; i < 40; i++) begin
            tick("t2_rr");
            if (bus.done != 2'b00 && nseen < 3) begin seen[nseen] = bus.done; nseen++; end
            bus.act_ack = m_act_en();
        end
        chk("t2_count", 4'(nseen), 4'd3);
        chk("t2_first", {2'b00, seen[0]}, 4'b0001);
        chk("t2_second", {2'b00, seen[1]}, 4'b0010);
        chk("t2_third", {2'b00, seen[2]}, 4'b0001);
        bus.req = 2'b00;
        for (int i = 0; i < 12; i++) begin tick("t2_drain"); bus.act_ack = m_act_en(); end
        bus.act_ack = 1'b0;
        tick("t2_idle");

        // Arm timeout into ERR.
        bus.req = 2'b10;
        ticks("t3_arm", 6);
        chk("t3_arm_state", {1'b0, bus.state_o}, 4'd1);
        tick("t3_err");
        chk("t3_err", {bus.err, bus.state_o}, 4'b1100);
        chk("t3_err_outs", {bus.gnt, bus.act_en, bus.busy}, 4'b0001);
        bus.req = 2'b01;
        ticks("t3_ignored", 2);
        bus.clr_err = 1'b1; bus.req = 2'b00;
        tick("t3_clr");
        chk("t3_clr", {bus.err, bus.state_o}, 4'h0);
        bus.clr_err = 1'b0;

        // Early release by dropping request in the second HOLD cycle.
        bus.req = 2'b01;
        tick("t4_arm");
        bus.act_ack = 1'b1;
        ticks("t4_hold", 2);
        bus.req = 2'b00;
        tick("t4_rel");
        chk("t4_rel", {bus.state_o, bus.act_en}, 4'b0110);
        bus.act_ack = 1'b0;
        tick("t4_done");
        chk("t4_done", {2'b00, bus.done}, 4'b0001);

        // Ack stuck high during release.
        bus.req = 2'b10;
        tick("t5_arm");
        bus.act_ack = 1'b1;
        ticks("t5_hold", 4);
        ticks("t5_rel", 6);
        chk("t5_rel_state", {1'b0, bus.state_o}, 4'd3);
        tick("t5_err");
        chk("t5_err", {bus.err, bus.state_o}, 4'b1100);
        bus.clr_err = 1'b1; bus.act_ack = 1'b0; bus.req = 2'b00;
        tick("t5_clr");
        bus.clr_err = 1'b0;
        bus.req = 2'b01;
        tick("t5_arm2");
        bus.act_ack = 1'b1;
        ticks("t5_hold2", 2);
        rst_n = 1'b0;
        tick("t5_reset");
        chk("t5_reset_outs", {bus.gnt, bus.act_en, bus.busy}, 4'h0);
        chk("t5_reset_state", {bus.err, bus.state_o}, 4'h0);
        rst_n = 1'b1; bus.req = 2'b00; bus.act_ack = 1'b0;
        tick("t5_idle");

        // ena=0 freezes HOLD.
        bus.req = 2'b01;
        tick("t6_arm");
        bus.act_ack = 1'b1;
        ticks("t6_hold", 2);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick("t6_frozen");
            chk("t6_frozen", {bus.state_o, bus.act_en}, 4'b0101);
        end
        ena = 1'b1;
        ticks("t6_hold_rest", 2);
        chk("t6_hold_last", {1'b0, bus.state_o}, 4'd2);
        tick("t6_rel");
        chk("t6_rel", {1'b0, bus.state_o}, 4'd3);
        bus.act_ack = 1'b0; bus.req = 2'b00;
        tick("t6_done");
        chk("t6_done", {2'b00, bus.done}, 4'b0001);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            ena         = ($urandom_range(0, 9) != 0);
            bus.clr_err = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) bus.req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) != 0) bus.act_ack = m_act_en();
            else                           bus.act_ack = 1'($urandom_range(0, 1));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
